// File: rtl/mem_wb_dmem_ctrl_pkg.sv
// Shared types for the MEM->WB data memory controller:
// load funct3 codes, controller state, and the MEM/WB latch bundle.
package mem_wb_dmem_ctrl_pkg;

   localparam int XLEN = 32;

   typedef enum logic [2:0] {
      F3_LB  = 3'b000,
      F3_LH  = 3'b001,
      F3_LW  = 3'b010,
      F3_LBU = 3'b100,
      F3_LHU = 3'b101
   } load_funct3_t;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } dmem_state_t;

   typedef struct packed {
      logic            valid;
      logic [4:0]      rd;
      logic            load_regfile;
      logic [XLEN-1:0] data;
      logic            halt_en;
   } mem_wb_latch_t;

   // size is funct3[1:0]: 01 half, 10 word; stores share the encoding
   function automatic logic misaligned(input logic [1:0] size,
                                       input logic [1:0] off);
      return ((size == 2'b01) && off[0]) ||
             ((size == 2'b10) && (off != 2'b00));
   endfunction

endpackage

// File: rtl/mem_wb_dmem_ctrl_if.sv
// Data cache request/response bus.
// master: controller drives request; slave: cache drives rdata/resp.
interface mem_wb_dmem_ctrl_if #(
   parameter int width = 32
) ();

   logic             data_read;
   logic             data_write;
   logic [3:0]       data_mbe;
   logic [width-1:0] data_addr;
   logic [width-1:0] data_wdata;
   logic [width-1:0] data_rdata;
   logic             data_resp;

   modport master (
      output data_read, data_write, data_mbe,
      output data_addr, data_wdata,
      input  data_rdata, data_resp
   );

   modport slave (
      input  data_read, data_write, data_mbe,
      input  data_addr, data_wdata,
      output data_rdata, data_resp
   );

endinterface

// File: rtl/mem_wb_dmem_ctrl_load_align.sv
// Load alignment: shifts the cache word by the byte offset and
// sign/zero-extends per funct3. Ports: rdata, offset, funct3 -> word.
module mem_wb_dmem_ctrl_load_align
   import mem_wb_dmem_ctrl_pkg::*;
#(
   parameter int width = XLEN
) (
   input  logic [width-1:0] rdata,
   input  logic [1:0]       offset,
   input  logic [2:0]       funct3,
   output logic [width-1:0] word
);

   logic [width-1:0] shifted;

   always_comb begin
      shifted = rdata >> {offset, 3'b000};
      word    = shifted;
      unique case (funct3)
         F3_LB:   word = {{(width-8){shifted[7]}}, shifted[7:0]};
         F3_LH:   word = {{(width-16){shifted[15]}}, shifted[15:0]};
         F3_LBU:  word = {{(width-8){1'b0}}, shifted[7:0]};
         F3_LHU:  word = {{(width-16){1'b0}}, shifted[15:0]};
         default: word = shifted;
      endcase
   end

endmodule

// File: rtl/mem_wb_dmem_ctrl.sv
// MEM->WB controller: holds one data cache request, stalls until resp,
// aligns load data and drives the MEM/WB latch. Cache bus on dmem.
module mem_wb_dmem_ctrl
   import mem_wb_dmem_ctrl_pkg::*;
#(
   parameter int width = XLEN
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_i,
   input  logic             mem_read_i,
   input  logic             mem_write_i,
   input  logic [width-1:0] addr_i,
   input  logic [width-1:0] wdata_i,
   input  logic [3:0]       byte_en_i,
   input  logic [2:0]       funct3_i,
   input  logic [4:0]       rd_i,
   input  logic             load_regfile_i,
   input  logic [width-1:0] alu_out_i,
   input  logic             halt_en_i,
   output logic             stall_o,
   mem_wb_dmem_ctrl_if.master dmem,
   output logic             wb_valid_o,
   output logic [4:0]       wb_rd_o,
   output logic             wb_load_regfile_o,
   output logic [width-1:0] wb_data_o,
   output logic             wb_halt_en_o,
   output logic             misalign_o
);

   dmem_state_t      state;
   logic             read_q;
   logic             write_q;
   logic [width-1:0] addr_q;
   logic [width-1:0] wdata_q;
   logic [3:0]       mbe_q;
   logic [2:0]       f3_q;
   logic [4:0]       rd_q;
   logic             ld_q;
   logic             halt_q;
   logic             misalign_q;
   mem_wb_latch_t    wb_q;
   logic [width-1:0] load_word;

   logic mem_op;
   logic bad;
   logic accept;

   assign mem_op = valid_i & (mem_read_i | mem_write_i);
   assign bad    = mem_op & misaligned(funct3_i[1:0], addr_i[1:0]);
   assign accept = (state == IDLE) & mem_op & ~bad;

   assign stall_o = accept | ((state == BUSY) & ~dmem.data_resp);

   mem_wb_dmem_ctrl_load_align #(.width(width)) u_align (
      .rdata  (dmem.data_rdata),
      .offset (addr_q[1:0]),
      .funct3 (f3_q),
      .word   (load_word)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         read_q     <= 1'b0;
         write_q    <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         mbe_q      <= '0;
         f3_q       <= '0;
         rd_q       <= '0;
         ld_q       <= 1'b0;
         halt_q     <= 1'b0;
         misalign_q <= 1'b0;
         wb_q       <= '0;
      end else begin
         misalign_q <= 1'b0;
         unique case (state)
            IDLE: begin
               unique case (1'b1)
                  !valid_i: wb_q <= '0;
                  bad: begin
                     misalign_q <= 1'b1;
                     wb_q <= '{valid: 1'b1, rd: rd_i,
                               load_regfile: 1'b0,
                               data: alu_out_i,
                               halt_en: halt_en_i};
                  end
                  accept: begin
                     state   <= BUSY;
                     read_q  <= mem_read_i;
                     write_q <= mem_write_i & ~mem_read_i;
                     addr_q  <= addr_i;
                     wdata_q <= wdata_i;
                     mbe_q   <= byte_en_i;
                     f3_q    <= funct3_i;
                     rd_q    <= rd_i;
                     ld_q    <= load_regfile_i;
                     halt_q  <= halt_en_i;
                     wb_q    <= '0;
                  end
                  default: begin
                     wb_q <= '{valid: 1'b1, rd: rd_i,
                               load_regfile: load_regfile_i,
                               data: alu_out_i,
                               halt_en: halt_en_i};
                  end
               endcase
            end
            BUSY: begin
               if (dmem.data_resp) begin
                  state   <= IDLE;
                  read_q  <= 1'b0;
                  write_q <= 1'b0;
                  wb_q <= '{valid: 1'b1, rd: rd_q,
                            load_regfile: ld_q,
                            data: read_q ? load_word : '0,
                            halt_en: halt_q};
               end else begin
                  wb_q <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign dmem.data_read  = read_q;
   assign dmem.data_write = write_q;
   assign dmem.data_mbe   = mbe_q;
   assign dmem.data_addr  = {addr_q[width-1:2], 2'b00};
   assign dmem.data_wdata = wdata_q;

   assign wb_valid_o        = wb_q.valid;
   assign wb_rd_o           = wb_q.rd;
   assign wb_load_regfile_o = wb_q.load_regfile;
   assign wb_data_o         = wb_q.data;
   assign wb_halt_en_o      = wb_q.halt_en;
   assign misalign_o        = misalign_q;

endmodule

// File: tb/tb_mem_wb_dmem_ctrl.sv
// Directed bench for mem_wb_dmem_ctrl: ALU pass-through, loads,
// store, misaligned drop and reset during an outstanding request.
module tb_mem_wb_dmem_ctrl;
   import mem_wb_dmem_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_i, mem_read_i, mem_write_i;
   logic [31:0] addr_i, wdata_i, alu_out_i;
   logic [3:0]  byte_en_i;
   logic [2:0]  funct3_i;
   logic [4:0]  rd_i;
   logic        load_regfile_i, halt_en_i;
   logic        stall_o, wb_valid_o, wb_load_regfile_o;
   logic [4:0]  wb_rd_o;
   logic [31:0] wb_data_o;
   logic        wb_halt_en_o, misalign_o;

   int checks = 0;
   int errors = 0;
   int stalls, reqs;
   logic [31:0] a_seen, wd_seen;
   logic [3:0]  be_seen;

   always #5 clk = ~clk;

   mem_wb_dmem_ctrl_if #(.width(32)) dmem ();

   mem_wb_dmem_ctrl #(.width(32)) dut (
      .clk               (clk),
      .rst               (rst),
      .valid_i           (valid_i),
      .mem_read_i        (mem_read_i),
      .mem_write_i       (mem_write_i),
      .addr_i            (addr_i),
      .wdata_i           (wdata_i),
      .byte_en_i         (byte_en_i),
      .funct3_i          (funct3_i),
      .rd_i              (rd_i),
      .load_regfile_i    (load_regfile_i),
      .alu_out_i         (alu_out_i),
      .halt_en_i         (halt_en_i),
      .stall_o           (stall_o),
      .dmem              (dmem),
      .wb_valid_o        (wb_valid_o),
      .wb_rd_o           (wb_rd_o),
      .wb_load_regfile_o (wb_load_regfile_o),
      .wb_data_o         (wb_data_o),
      .wb_halt_en_o      (wb_halt_en_o),
      .misalign_o        (misalign_o)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic idle();
      valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
      addr_i = '0; wdata_i = '0; byte_en_i = '0; funct3_i = '0;
      rd_i = '0; load_regfile_i = 1'b0; alu_out_i = '0;
      halt_en_i = 1'b0;
   endtask

   // lat = BUSY cycles up to and including the resp cycle (>= 1)
   task automatic mem_op(input logic rd_en, input logic wr_en,
                         input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be,
                         input logic [4:0] rdn, input logic ld,
                         input int lat, input logic [31:0] rdat,
                         output int st, output int rq,
                         output logic [31:0] as, output logic [31:0] ws,
                         output logic [3:0] bs);
      @(negedge clk);
      valid_i = 1'b1; mem_read_i = rd_en; mem_write_i = wr_en;
      funct3_i = f3; addr_i = a; wdata_i = wd; byte_en_i = be;
      rd_i = rdn; load_regfile_i = ld; alu_out_i = 32'hA5A5_0000;
      st = 0; rq = 0; as = '0; ws = '0; bs = '0;
      for (int c = 0; c <= lat; c++) begin
         if (c > 0) @(negedge clk);
         if (c == lat) begin
            dmem.data_resp = 1'b1;
            dmem.data_rdata = rdat;
         end
         #1;
         st += int'(stall_o);
         rq += int'(dmem.data_read | dmem.data_write);
         if (c == 1) begin
            as = dmem.data_addr;
            ws = dmem.data_wdata;
            bs = dmem.data_mbe;
         end
      end
      @(negedge clk);
      dmem.data_resp = 1'b0;
      dmem.data_rdata = '0;
      idle();
   endtask

   initial begin
      rst = 1'b0;
      idle();
      dmem.data_resp = 1'b0;
      dmem.data_rdata = '0;
      #12;
      chk("rst_wb_valid", wb_valid_o, 0);
      chk("rst_read", dmem.data_read, 0);
      chk("rst_write", dmem.data_write, 0);
      chk("rst_stall", stall_o, 0);
      chk("rst_misalign", misalign_o, 0);
      chk("rst_wb_data", wb_data_o, 0);
      @(negedge clk);
      rst = 1'b1;

      // ALU op
      @(negedge clk);
      valid_i = 1'b1; alu_out_i = 32'h0000_1234; rd_i = 5'd5;
      load_regfile_i = 1'b1;
      #1 chk("alu_stall", stall_o, 0);
      @(posedge clk); #1;
      chk("alu_valid", wb_valid_o, 1);
      chk("alu_rd", wb_rd_o, 5);
      chk("alu_data", wb_data_o, 32'h0000_1234);
      chk("alu_ld", wb_load_regfile_o, 1);
      chk("alu_stall2", stall_o, 0);

      // ALU op to x0 carrying halt
      @(negedge clk);
      rd_i = 5'd0; alu_out_i = 32'hCAFE_0001; halt_en_i = 1'b1;
      @(posedge clk); #1;
      chk("x0_rd", wb_rd_o, 0);
      chk("x0_halt", wb_halt_en_o, 1);
      chk("x0_data", wb_data_o, 32'hCAFE_0001);

      // lb @0x100, resp 3 cycles after BUSY entry
      mem_op(1, 0, F3_LB, 32'h100, 0, 4'h0, 5'd9, 1, 3,
             32'h80FF_7F01, stalls, reqs, a_seen, wd_seen, be_seen);
      #1;
      chk("lb_stalls", stalls, 3);
      chk("lb_reqs", reqs, 3);
      chk("lb_addr", a_seen, 32'h100);
      chk("lb_data", wb_data_o, 32'h0000_0001);
      chk("lb_valid", wb_valid_o, 1);
      chk("lb_rd", wb_rd_o, 9);
      chk("lb_read_off", dmem.data_read, 0);

      // lhu / lh @0x102
      mem_op(1, 0, F3_LHU, 32'h102, 0, 4'h0, 5'd3, 1, 1,
             32'h80FF_7F01, stalls, reqs, a_seen, wd_seen, be_seen);
      #1;
      chk("lhu_addr", a_seen, 32'h100);
      chk("lhu_data", wb_data_o, 32'h0000_80FF);
      chk("lhu_stalls", stalls, 1);
      mem_op(1, 0, F3_LH, 32'h102, 0, 4'h0, 5'd3, 1, 2,
             32'h80FF_7F01, stalls, reqs, a_seen, wd_seen, be_seen);
      #1;
      chk("lh_data", wb_data_o, 32'hFFFF_80FF);
      chk("lh_stalls", stalls, 2);

      // byte lanes 1 and 3
      mem_op(1, 0, F3_LB, 32'h101, 0, 4'h0, 5'd4, 1, 1,
             32'h80FF_7F01, stalls, reqs, a_seen, wd_seen, be_seen);
      #1 chk("lb1_data", wb_data_o, 32'h0000_007F);
      mem_op(1, 0, F3_LB, 32'h103, 0, 4'h0, 5'd4, 1, 1,
             32'h80FF_7F01, stalls, reqs, a_seen, wd_seen, be_seen);
      #1 chk("lb3_data", wb_data_o, 32'hFFFF_FF80);
      mem_op(1, 0, F3_LBU, 32'h103, 0, 4'h0, 5'd4, 1, 1,
             32'h80FF_7F01, stalls, reqs, a_seen, wd_seen, be_seen);
      #1 chk("lbu3_data", wb_data_o, 32'h0000_0080);
      mem_op(1, 0, F3_LW, 32'h104, 0, 4'h0, 5'd4, 1, 1,
             32'h1234_5678, stalls, reqs, a_seen, wd_seen, be_seen);
      #1 chk("lw_data", wb_data_o, 32'h1234_5678);

      // sw @0x204, resp in first BUSY cycle
      mem_op(0, 1, F3_LW, 32'h204, 32'hDEAD_BEEF, 4'hF, 5'd0, 0, 1,
             32'h0, stalls, reqs, a_seen, wd_seen, be_seen);
      #1;
      chk("sw_reqs", reqs, 1);
      chk("sw_stalls", stalls, 1);
      chk("sw_addr", a_seen, 32'h204);
      chk("sw_wdata", wd_seen, 32'hDEAD_BEEF);
      chk("sw_mbe", be_seen, 4'hF);
      chk("sw_ld", wb_load_regfile_o, 0);
      chk("sw_valid", wb_valid_o, 1);
      chk("sw_data", wb_data_o, 0);
      chk("sw_write_off", dmem.data_write, 0);
      chk("sw_stall_after", stall_o, 0);

      // misaligned lw @0x103
      @(negedge clk);
      valid_i = 1'b1; mem_read_i = 1'b1; funct3_i = F3_LW;
      addr_i = 32'h103; rd_i = 5'd7; load_regfile_i = 1'b1;
      #1;
      chk("mis_stall", stall_o, 0);
      chk("mis_read", dmem.data_read, 0);
      @(posedge clk); #1;
      chk("mis_pulse", misalign_o, 1);
      chk("mis_valid", wb_valid_o, 1);
      chk("mis_ld", wb_load_regfile_o, 0);
      chk("mis_rd", wb_rd_o, 7);
      chk("mis_read2", dmem.data_read, 0);
      @(negedge clk);
      idle();
      @(posedge clk); #1;
      chk("mis_pulse_end", misalign_o, 0);
      chk("mis_bubble", wb_valid_o, 0);

      // reset while a lw is outstanding
      @(negedge clk);
      valid_i = 1'b1; mem_read_i = 1'b1; funct3_i = F3_LW;
      addr_i = 32'h300; rd_i = 5'd8; load_regfile_i = 1'b1;
      @(posedge clk); #1;
      chk("rb_read", dmem.data_read, 1);
      @(negedge clk); #2;
      rst = 1'b0;
      #1;
      chk("rb_read_async", dmem.data_read, 0);
      chk("rb_wb_valid", wb_valid_o, 0);
      idle();
      @(negedge clk);
      rst = 1'b1;
      dmem.data_resp = 1'b1;
      dmem.data_rdata = 32'hFFFF_FFFF;
      #1 chk("rb_stall", stall_o, 0);
      @(posedge clk); #1;
      chk("rb_read_after", dmem.data_read, 0);
      chk("rb_wb_after", wb_valid_o, 0);
      chk("rb_data_after", wb_data_o, 0);
      @(negedge clk);
      dmem.data_resp = 1'b0;
      @(posedge clk); #1;
      chk("rb_idle_wb", wb_valid_o, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
